// File: rtl/socaudio_ram_reader.sv
// Avalon-MM read master that fetches a block of 32-bit words from the sample RAM
// and streams them as left/right 16-bit PCM samples on an Avalon-ST source.
module socaudio_ram_reader #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ctl_start,
    input  logic              ctl_stop,
    input  logic              ctl_loop,
    input  logic [ADDR_W-1:0] ctl_start_addr,
    input  logic [ADDR_W:0]   ctl_num_words,
    output logic              ctl_busy,
    output logic              ctl_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    output logic [15:0]       aso_data,
    output logic              aso_channel,
    output logic              aso_valid,
    input  logic              aso_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_ABORT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   off_q, off_d;
    logic              loop_q, loop_d;
    logic              inflight_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              half_q, half_d;
    logic [31:0]       mem [FIFO_DEPTH];

    logic [CW:0] occ;
    logic        rd, last, flush, push, fire, pop;
    logic [31:0] head;

    assign occ   = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
    assign rd    = (state_q == S_RUN) && (occ < DEPTH_C);
    assign last  = (off_q == len_q - ONE_W);
    // A stop empties the buffer at once so the sink sees valid drop next cycle
    assign flush = ctl_stop && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign push  = inflight_q && (state_q != S_ABORT) && !flush;
    assign fire  = aso_valid && aso_ready;
    assign pop   = fire && half_q;
    assign head  = mem[rptr_q];

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        loop_d  = loop_q;
        off_d   = off_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctl_start) begin
                    start_d = ctl_start_addr;
                    len_d   = ctl_num_words;
                    loop_d  = ctl_loop;
                    off_d   = '0;
                    if (ctl_num_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ctl_stop) begin
                    state_d = S_ABORT;
                end else if (rd) begin
                    if (!last) begin
                        off_d = off_q + ONE_W;
                    end else if (loop_q) begin
                        off_d = '0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ctl_stop) begin
                    state_d = S_ABORT;
                end else if (!inflight_q && cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_ABORT: begin
                if (!inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        half_d = fire ? ~half_q : half_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            half_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            off_q      <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            half_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            off_q      <= off_d;
            inflight_q <= rd;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= avm_readdata;
        end
    end

    assign ctl_busy       = busy_q;
    assign ctl_done       = done_q;
    assign avm_read       = rd;
    assign avm_chipselect = rd;
    assign avm_byteenable = 4'hF;
    assign avm_address    = rd ? (start_q + off_q[ADDR_W-1:0]) : '0;
    assign aso_valid      = (cnt_q != '0);
    assign aso_channel    = aso_valid && half_q;
    assign aso_data       = !aso_valid ? 16'h0000 :
                            (half_q ? head[31:16] : head[15:0]);

endmodule

// File: tb/tb_socaudio_ram_reader.sv
// Directed bench for socaudio_ram_reader with a latency-1 RAM model.
module tb_socaudio_ram_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctl_start = 1'b0;
    logic        ctl_stop = 1'b0;
    logic        ctl_loop = 1'b0;
    logic [11:0] ctl_start_addr = '0;
    logic [12:0] ctl_num_words = '0;
    logic        ctl_busy, ctl_done;
    logic [11:0] avm_address;
    logic        avm_chipselect, avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] rdata = '0;
    logic [15:0] aso_data;
    logic        aso_channel, aso_valid;
    logic        aso_ready = 1'b0;

    logic [31:0] ram [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) if (avm_read) rdata <= ram[avm_address];

    socaudio_ram_reader #(.ADDR_W(12), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_loop(ctl_loop),
        .ctl_start_addr(ctl_start_addr), .ctl_num_words(ctl_num_words),
        .ctl_busy(ctl_busy), .ctl_done(ctl_done),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_readdata(rdata),
        .aso_data(aso_data), .aso_channel(aso_channel),
        .aso_valid(aso_valid), .aso_ready(aso_ready)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int t_start = 0;
    int first_rd, first_val, ndone, done_cyc, nbusy;
    logic [11:0] rd_q [$];
    logic [16:0] smp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avm_read) begin
            rd_q.push_back(avm_address);
            if (first_rd < 0) first_rd = cyc;
        end
        if (aso_valid && first_val < 0) first_val = cyc;
        if (aso_valid && aso_ready) smp_q.push_back({aso_channel, aso_data});
        if (ctl_done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (ctl_busy) nbusy++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        smp_q.delete();
        first_rd = -1;
        first_val = -1;
        ndone = 0;
        done_cyc = -1;
        nbusy = 0;
    endtask

    task automatic start_xfer(input logic [11:0] a, input logic [12:0] n, input logic lp);
        @(posedge clk); #1;
        ctl_start_addr = a;
        ctl_num_words = n;
        ctl_loop = lp;
        ctl_start = 1'b1;
        t_start = cyc;
        @(posedge clk); #1;
        ctl_start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int i = 0;
        while (ndone == 0 && i < max) begin
            @(posedge clk);
            i++;
        end
        chk("done_seen", 32'(ndone != 0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(ctl_busy), 32'd0);
        chk({tag, "_done"}, 32'(ctl_done), 32'd0);
        chk({tag, "_read"}, 32'(avm_read), 32'd0);
        chk({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
        chk({tag, "_addr"}, 32'(avm_address), 32'd0);
        chk({tag, "_be"}, 32'(avm_byteenable), 32'hF);
        chk({tag, "_valid"}, 32'(aso_valid), 32'd0);
        chk({tag, "_data"}, 32'(aso_data), 32'd0);
        chk({tag, "_chan"}, 32'(aso_channel), 32'd0);
    endtask

    task automatic run_basic(input string tag);
        clear_mon();
        aso_ready = 1'b1;
        start_xfer(12'h010, 13'd4, 1'b0);
        wait_done(100);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_nrd"}, 32'(rd_q.size()), 32'd4);
        chk({tag, "_nsmp"}, 32'(smp_q.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_q.size())
                chk({tag, "_addr"}, 32'(rd_q[i]), 32'h010 + 32'(i));
            if (2 * i + 1 < smp_q.size()) begin
                chk({tag, "_left"}, 32'(smp_q[2*i]), {15'd0, 1'b0, 16'hAAAA + 16'(i)});
                chk({tag, "_right"}, 32'(smp_q[2*i+1]), {15'd0, 1'b1, 16'hBBBB});
            end
        end
        chk({tag, "_rd_lat"}, 32'(first_rd - t_start), 32'd1);
        chk({tag, "_val_lat"}, 32'(first_val - t_start), 32'd3);
        chk({tag, "_ndone"}, 32'(ndone), 32'd1);
        chk({tag, "_busy_end"}, 32'(ctl_busy), 32'd0);
    endtask

    initial begin
        logic [11:0] wrap_a [4];
        int n0;
        wrap_a[0] = 12'hFFE; wrap_a[1] = 12'hFFF;
        wrap_a[2] = 12'h000; wrap_a[3] = 12'h001;
        for (int i = 0; i < 4096; i++) ram[i] = 32'hDEAD_0000 + 32'(i);
        for (int i = 0; i < 4; i++) ram[12'h010 + i] = 32'hBBBB_AAAA + 32'(i);
        for (int i = 0; i < 20; i++)
            ram[12'h200 + i] = {16'h2000 + 16'(2*i+1), 16'h2000 + 16'(2*i)};
        for (int i = 0; i < 4; i++)
            ram[wrap_a[i]] = {16'(2*i+2), 16'(2*i+1)};
        ram[12'h100] = 32'hA1A1_A0A0;
        ram[12'h101] = 32'hB1B1_B0B0;
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        reset_n = 1'b1;

        run_basic("basic");

        // Backpressure: buffer fills, reads stop, then everything drains in order
        clear_mon();
        aso_ready = 1'b0;
        start_xfer(12'h200, 13'd20, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("bp_nrd_held", 32'(rd_q.size()), 32'd8);
        chk("bp_read_low", 32'(avm_read), 32'd0);
        chk("bp_hold_data", 32'(aso_data), 32'h2000);
        chk("bp_hold_chan", 32'(aso_channel), 32'd0);
        aso_ready = 1'b1;
        wait_done(300);
        chk("bp_nrd", 32'(rd_q.size()), 32'd20);
        chk("bp_nsmp", 32'(smp_q.size()), 32'd40);
        for (int k = 0; k < 40; k++)
            if (k < smp_q.size())
                chk("bp_smp", 32'(smp_q[k]), {15'd0, 1'(k & 1), 16'h2000 + 16'(k)});

        // Address wrap at the top of the RAM
        clear_mon();
        start_xfer(12'hFFE, 13'd4, 1'b0);
        wait_done(100);
        chk("wrap_nrd", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < rd_q.size()) chk("wrap_addr", 32'(rd_q[i]), 32'(wrap_a[i]));
        chk("wrap_nsmp", 32'(smp_q.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < smp_q.size())
                chk("wrap_smp", 32'(smp_q[k]), {15'd0, 1'(k & 1), 16'(k + 1)});

        // Zero-length block
        clear_mon();
        start_xfer(12'h300, 13'd0, 1'b0);
        wait_done(10);
        repeat (3) @(posedge clk);
        chk("zero_nrd", 32'(rd_q.size()), 32'd0);
        chk("zero_done_lat", 32'(done_cyc - t_start), 32'd2);
        chk("zero_busy", 32'(nbusy), 32'd0);
        chk("zero_ndone", 32'(ndone), 32'd1);

        // Looping block, then abort
        clear_mon();
        start_xfer(12'h100, 13'd2, 1'b1);
        repeat (20) @(posedge clk);
        chk("loop_no_done", 32'(ndone), 32'd0);
        chk("loop_nrd_ge6", 32'(rd_q.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            if (i < rd_q.size())
                chk("loop_addr", 32'(rd_q[i]), 32'h100 + 32'(i & 1));
        if (smp_q.size() >= 6) begin
            chk("loop_s0", 32'(smp_q[0]), 32'h0_A0A0);
            chk("loop_s1", 32'(smp_q[1]), 32'h1_A1A1);
            chk("loop_s2", 32'(smp_q[2]), 32'h0_B0B0);
            chk("loop_s3", 32'(smp_q[3]), 32'h1_B1B1);
            chk("loop_s4", 32'(smp_q[4]), 32'h0_A0A0);
        end else begin
            chk("loop_nsmp_ge6", 32'(smp_q.size() >= 6), 32'd1);
        end
        @(posedge clk); #1;
        ctl_stop = 1'b1;
        @(posedge clk); #1;
        ctl_stop = 1'b0;
        chk("stop_valid_low", 32'(aso_valid), 32'd0);
        wait_done(20);
        repeat (3) @(posedge clk);
        n0 = rd_q.size();
        repeat (5) @(posedge clk);
        #1;
        chk("stop_ndone", 32'(ndone), 32'd1);
        chk("stop_no_reads", 32'(rd_q.size()), 32'(n0));
        chk("stop_busy", 32'(ctl_busy), 32'd0);

        // Asynchronous reset in the middle of a run
        clear_mon();
        start_xfer(12'h010, 13'd4, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_mon();
        repeat (10) @(posedge clk);
        chk("midrst_no_reads", 32'(rd_q.size()), 32'd0);
        chk("midrst_no_done", 32'(ndone), 32'd0);

        run_basic("again");

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/socaudio_ram_reader.md
Name: socaudio_ram_reader

Overview:
- Avalon-MM read master that streams audio out of the on-chip sample RAM: 12-bit word address, 32-bit data, fixed read latency 1, no waitrequest.
- Fetches a programmed block of 32-bit words and splits each word into two 16-bit PCM samples: left = bits 15:0, right = bits 31:16.
- Delivers samples on an Avalon-ST valid/ready source toward the audio codec serializer.
- Sits between the control/CSR logic and the RAM's second slave port.

Parameters:
- ADDR_W, 12, word address width of the RAM.
- FIFO_DEPTH, 8, number of 32-bit words buffered internally (power of 2, minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ctl_start  in  1  one-cycle pulse; begins a transfer when idle.
- ctl_stop  in  1  one-cycle pulse; aborts the active transfer.
- ctl_loop  in  1  sampled at start; 1 = restart the block endlessly.
- ctl_start_addr  in  ADDR_W  first word address; sampled at start.
- ctl_num_words  in  ADDR_W+1  words per block, 0..4096; sampled at start.
- ctl_busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- ctl_done  out  1  one-cycle pulse when a transfer completes or an abort finishes.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  equal to avm_read.
- avm_read  out  1  read strobe, at most one per cycle.
- avm_byteenable  out  4  constant 4'hF.
- avm_readdata  in  32  valid exactly one cycle after avm_read.
- aso_data  out  16  PCM sample.
- aso_channel  out  1  0 = left, 1 = right.
- aso_valid  out  1  sample valid.
- aso_ready  in  1  sink accepts when valid & ready.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0 except avm_byteenable = 4'hF. FIFO empty, in-flight flag clear, state IDLE.
- States:
  - IDLE: ctl_start → latch addr/len/loop. If len = 0, go to DONE. Otherwise go to RUN.
  - RUN: issue reads; after the last word of the block is issued, wrap to start_addr if loop = 1, else go to DRAIN.
  - DRAIN: wait until no read is in flight, the FIFO is empty and the current word's second sample is accepted, then go to DONE.
  - ABORT: entered from RUN or DRAIN on ctl_stop. Flush the FIFO and drop aso_valid next cycle. Discard any returning in-flight word, then go to DONE.
  - DONE: ctl_done = 1 for one cycle, ctl_busy = 0 in that same cycle, then go to IDLE.
- Read issue: in RUN, assert avm_read when fifo_count + inflight < FIFO_DEPTH. Back-to-back reads are allowed, giving 1 word/cycle sustained.
- Address: avm_address = start_addr + offset, modulo 2^ADDR_W, so 4095 wraps to 0. offset counts 0..len-1.
- Capture: readdata is written into the FIFO in the cycle after the read; the in-flight counter is at most 1 at fixed latency 1.
- Unpacking: the FIFO head word is presented as left (channel 0), then right (channel 1). The word is popped when the right sample is accepted.
  - aso_data/channel are stable while valid & ~ready.
  - Samples are never dropped or duplicated except on abort.
- Latency: a start pulse at cycle T gives the first avm_read at T+1 and the first aso_valid at T+3.
- Simultaneous events:
  - ctl_start while busy: ignored.
  - ctl_stop in IDLE or DONE: ignored.
  - ctl_start and ctl_stop in the same cycle while IDLE: start wins.
- Loop: at the block boundary, the address steps from start+len-1 to start with no idle cycle. ctl_done does not pulse until stopped.
- Reset asserted mid-transfer: outputs clear immediately and no further reads are issued.

Test Plan:
- start_addr = 0x010, num_words = 4, RAM[0x10..0x13] = 0xBBBB_AAAA+i, aso_ready = 1 → reads at 0x010..0x013 on consecutive cycles; 8 samples out in order AAAA,BBBB(+i) with channel alternating 0,1; exactly one ctl_done pulse.
- aso_ready held 0 with num_words = 20, FIFO_DEPTH = 8 → exactly 8 reads issued and then avm_read stays low; releasing ready yields all 40 samples in order with no loss.
- start_addr = 0xFFE, num_words = 4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- num_words = 0 → no avm_read; ctl_done pulses 2 cycles after start; ctl_busy stays 0 throughout.
- loop = 1, num_words = 2, start_addr = 0x100 → addresses 0x100, 0x101, 0x100, 0x101…; ctl_stop mid-stream → aso_valid low within 1 cycle, done pulses once, then IDLE.
- reset_n driven low for 1 cycle mid-RUN → all outputs 0 asynchronously; a new start after reset behaves as in the first scenario.
